s2_serial_receiver: RTL



---
 rtl/s2_serial_receiver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/s2_serial_receiver.sv
// rtl/s2_serial_receiver.sv - sen/sd bit-plane packet receiver that rebuilds an 18-byte block into RB2
module s2_serial_receiver #(
  parameter int NBYTES = 18,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sen,
  input  logic          sd,
  output logic          S2_done,
  output logic          RB2_RW,
  output logic [AW-1:0] RB2_A,
  output logic [7:0]    RB2_D
);

  localparam int PKT_BITS = 3 + NBYTES;
  localparam int CW       = $clog2(PKT_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(PKT_BITS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    COMMIT,
    WRITE,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [PKT_BITS-1:0] shreg;
  logic [CW-1:0]       cnt;
  logic [7:0]          mask;
  logic [7:0]          buffer  [NBYTES];
  logic [7:0]          buf_upd [NBYTES];

  logic [2:0]    pkt_addr;
  logic [7:0]    mask_upd;
  logic          mask_full;
  logic          start_bit;
  logic          shift_bit;
  logic [AW-1:0] next_addr;

  // After 21 shifts the address sits in the top three bits and byte j's bit lands at shreg[j].
  assign pkt_addr  = shreg[PKT_BITS-1 -: 3];
  assign mask_upd  = mask | (8'b1 << pkt_addr);
  assign mask_full = (mask_upd == 8'hFF);
  assign next_addr = RB2_A + AW'(1);

  assign start_bit = !sen && ((state == IDLE) || (state == COMMIT && !mask_full));
  assign shift_bit = !sen && (state == RECV) && (cnt != CNT_FULL);

  always_comb begin
    for (int j = 0; j < NBYTES; j++) begin
      buf_upd[j] = buffer[j];
      buf_upd[j][3'd7 - pkt_addr] = shreg[j];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!sen) state_nx = RECV;
      end
      RECV: begin
        if (sen) state_nx = (cnt == CNT_FULL) ? COMMIT : IDLE;
      end
      COMMIT: begin
        if (mask_full)  state_nx = WRITE;
        else if (!sen)  state_nx = RECV;
        else            state_nx = IDLE;
      end
      WRITE: begin
        if (RB2_A == LAST_ADDR) state_nx = DONE;
      end
      DONE: begin
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (start_bit || shift_bit) begin
        shreg <= {shreg[PKT_BITS-2:0], sd};
      end
      if (start_bit) begin
        cnt <= CW'(1);
      end else if (shift_bit) begin
        cnt <= cnt + CW'(1);
      end else if (state != RECV) begin
        cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
      for (int j = 0; j < NBYTES; j++) begin
        buffer[j] <= '0;
      end
    end else if (state == COMMIT) begin
      mask <= mask_upd;
      for (int j = 0; j < NBYTES; j++) begin
        buffer[j] <= buf_upd[j];
      end
    end
  end

  // Byte 0 is taken from the merged view so the first write already carries this packet's plane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      S2_done <= 1'b0;
      RB2_RW  <= 1'b1;
      RB2_A   <= '0;
      RB2_D   <= '0;
    end else begin
      case (state)
        COMMIT: begin
          if (mask_full) begin
            RB2_RW <= 1'b0;
            RB2_A  <= '0;
            RB2_D  <= buf_upd[0];
          end
        end
        WRITE: begin
          if (RB2_A == LAST_ADDR) begin
            RB2_RW  <= 1'b1;
            S2_done <= 1'b1;
          end else begin
            RB2_A <= next_addr;
            RB2_D <= buffer[next_addr];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
